mux16_rr_sched: RTL and testbench
=================================

MUX16_RR_SCHED -- requirements
Module: mux16_rr_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, giving beats per grant; legal range 1..16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req, input, 16, one request line per mux input channel.
REQ-005 SHALL have port data, input, 16, the mux data inputs; bit i belongs to channel i.
REQ-006 SHALL have port out_ready, input, 1, consumer ready.
REQ-007 SHALL have port sel, output, 4, the registered mux select, which is the granted channel index.
REQ-008 SHALL have port grant, output, 16, registered one-hot grant, all-zero when not transferring.
REQ-009 SHALL have port out_bit, output, 1, equal to data[sel] combinationally (16:1 selection).
REQ-010 SHALL have port out_valid, output, 1, beat valid.
REQ-011 SHALL have port burst_done, output, 1, a registered one-cycle pulse at burst end.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and XFER.
REQ-013 IDLE: if req != 0 at an edge, the block SHALL select the winner, load sel, set grant to one-hot(winner), clear the beat counter, and enter XFER on that edge.
REQ-014 The winner SHALL be the first asserted req index found searching from (last+1) mod 16 upward with wrap.
  - last is the index of the previous grant.
  - The search includes last itself, as the final candidate.
REQ-015 last SHALL update to the winner on every IDLE-to-XFER transition.
REQ-016 IDLE with req == 0 SHALL hold sel, keep grant = 0, and stay in IDLE.
REQ-017 In XFER, out_valid SHALL be 1 iff req[sel] == 1; it SHALL be 0 in IDLE.
REQ-018 A beat SHALL be an edge with out_valid & out_ready; each beat increments the 5-bit beat counter.
REQ-019 XFER with out_valid & !out_ready SHALL hold sel, grant and the counter (stall); out_bit continues to follow data[sel].
REQ-020 On the beat where counter == BURST_LEN-1, the block SHALL return to IDLE, clear grant, and assert burst_done for the next cycle.
REQ-021 XFER with req[sel] == 0 at an edge (early withdraw) SHALL return to IDLE and clear grant; burst_done SHALL NOT be asserted.
REQ-022 Every grant SHALL be followed by at least one IDLE cycle; there are no back-to-back grants without an arbitration cycle.
REQ-023 A change to req of non-granted channels during XFER SHALL have no effect until the next IDLE.
REQ-024 With BURST_LEN = 1, a single beat SHALL end the burst.
REQ-025 The counter SHALL never exceed BURST_LEN-1; it has no wrap-around path.

Reset
REQ-026 When rst = 1 at an edge, the block SHALL set: state IDLE, sel = 0, grant = 0, counter = 0, last = 15, burst_done = 0; out_valid is therefore 0.
REQ-027 rst SHALL override all other inputs, including mid-XFER, with no burst_done pulse.
REQ-028 After reset, the first arbitration SHALL search from channel 0.

Verification
REQ-029 Reset then req = 16'h0001, out_ready = 1, BURST_LEN = 4 -> 1 cycle later sel = 0, grant = 16'h0001, out_valid high for 4 cycles, then burst_done pulse, then grant = 0.
REQ-030 req = 16'h8101 held, out_ready = 1 -> grant order ch0, ch8, ch15, ch0, each separated by one IDLE cycle.
REQ-031 Grant ch3 with out_ready = 0 for 5 cycles, then 1 -> sel stays 3, counter frozen, exactly 4 beats delivered after ready rises.
REQ-032 Grant ch5, drop req[5] after 2 beats -> IDLE next edge, no burst_done; next winner searched from ch6.
REQ-033 data = 16'hA5C3 with sel stepping through all channels -> out_bit matches data[sel] every cycle.
REQ-034 Assert rst mid-XFER (beat 2, ch9) -> next cycle grant = 0, out_valid = 0, sel = 0; next request from ch9 alone wins again.

Source files
------------

// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: round-robin 16:1 mux scheduler that grants one channel for up to BURST_LEN beats
module mux16_rr_sched #(
    parameter int BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic [15:0] data,
    input  logic        out_ready,
    output logic [3:0]  sel,
    output logic [15:0] grant,
    output logic        out_bit,
    output logic        out_valid,
    output logic        burst_done
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;
    logic [0:0]  state_q, state_d;
    logic [3:0]  sel_q, sel_d, last_q, last_d, win, idx;
    logic [15:0] grant_q, grant_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d, found;
    // Search starts just past the previous winner; the wrap lands on last itself as the final candidate
    always_comb begin
        win = last_q;
        found = 1'b0;
        idx = '0;
        for (int k = 1; k <= 16; k++) begin
            idx = last_q + 4'(k);
            if (!found && req[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
    end
    assign out_valid  = (state_q == XFER) && req[sel_q];
    assign out_bit    = data[sel_q];
    assign sel        = sel_q;
    assign grant      = grant_q;
    assign burst_done = done_q;
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = XFER;
                sel_d   = win;
                last_d  = win;
                grant_d = 16'(1) << win;
                cnt_d   = '0;
            end
        end else if (!req[sel_q]) begin
            state_d = IDLE;
            grant_d = '0;
        end else if (out_ready) begin
            state_d = (cnt_q == 5'(BURST_LEN - 1)) ? IDLE : XFER;
            grant_d = (cnt_q == 5'(BURST_LEN - 1)) ? 16'h0 : grant_q;
            done_d  = (cnt_q == 5'(BURST_LEN - 1));
            cnt_d   = (cnt_q == 5'(BURST_LEN - 1)) ? cnt_q : cnt_q + 5'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= 4'd15;
            grant_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb_mux16_rr_sched: scoreboard bench running BURST_LEN=4 and BURST_LEN=1 instances against a behavioural model
module tb_mux16_rr_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0, data = '0;
    logic        out_ready = 1'b0;
    logic [3:0]  sel4, sel1;
    logic [15:0] grant4, grant1;
    logic        ob4, ob1, ov4, ov1, bd4, bd1;
    int vectors = 0, miscompares = 0;

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] grant;
        logic        ov;
        logic        ob;
        logic        bd;
    } exp_t;

    typedef struct {
        bit busy;
        int ch;
        int last;
        int beats;
        bit done;
    } model_t;

    exp_t   q4[$], q1[$];
    model_t m4, m1;
    bit     known = 1'b0;

    always #5 clk = ~clk;

    mux16_rr_sched #(.BURST_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .data(data), .out_ready(out_ready),
        .sel(sel4), .grant(grant4), .out_bit(ob4), .out_valid(ov4), .burst_done(bd4));
    mux16_rr_sched #(.BURST_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .data(data), .out_ready(out_ready),
        .sel(sel1), .grant(grant1), .out_bit(ob1), .out_valid(ov1), .burst_done(bd1));

    function automatic model_t step(model_t s, bit r, logic [15:0] q, bit rdy, int bl);
        model_t n = s;
        n.done = 1'b0;
        if (r) begin
            n.busy = 1'b0; n.ch = 0; n.last = 15; n.beats = 0;
        end else if (!s.busy) begin
            for (int k = 1; k <= 16; k++) begin
                int c = (s.last + k) % 16;
                if (q[c]) begin
                    n.busy = 1'b1; n.ch = c; n.last = c; n.beats = 0;
                    break;
                end
            end
        end else if (!q[s.ch]) begin
            n.busy = 1'b0;
        end else if (rdy) begin
            n.beats = s.beats + 1;
            if (n.beats == bl) begin
                n.busy = 1'b0;
                n.done = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic exp_t expect_of(model_t s, logic [15:0] q, logic [15:0] d);
        exp_t e;
        e.sel   = 4'(s.ch);
        e.grant = s.busy ? (16'h1 << s.ch) : 16'h0;
        e.ov    = s.busy && q[s.ch];
        e.ob    = d[s.ch];
        e.bd    = s.done;
        return e;
    endfunction

    task automatic cyc(input bit r, input logic [15:0] q, input logic [15:0] d, input bit rdy);
        @(posedge clk);
        #1;
        if (rst) known = 1'b1;
        m4 = step(m4, rst, req, out_ready, 4);
        m1 = step(m1, rst, req, out_ready, 1);
        rst = r; req = q; data = d; out_ready = rdy;
        if (known) begin
            q4.push_back(expect_of(m4, q, d));
            q1.push_back(expect_of(m1, q, d));
        end
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        if (q4.size() != 0) begin
            e = q4.pop_front();
            a = '{sel: sel4, grant: grant4, ov: ov4, ob: ob4, bd: bd4};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL bl4 t=%0t got sel=%0d grant=%h ov=%b ob=%b bd=%b want sel=%0d grant=%h ov=%b ob=%b bd=%b",
                         $time, a.sel, a.grant, a.ov, a.ob, a.bd, e.sel, e.grant, e.ov, e.ob, e.bd);
            end
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            a = '{sel: sel1, grant: grant1, ov: ov1, ob: ob1, bd: bd1};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL bl1 t=%0t got sel=%0d grant=%h ov=%b ob=%b bd=%b want sel=%0d grant=%h ov=%b ob=%b bd=%b",
                         $time, a.sel, a.grant, a.ov, a.ob, a.bd, e.sel, e.grant, e.ov, e.ob, e.bd);
            end
        end
    end

    initial begin
        logic [15:0] rq;
        m4 = '{busy: 0, ch: 0, last: 15, beats: 0, done: 0};
        m1 = m4;
        // single requester, full burst
        cyc(1, 0, 16'h1234, 1);
        repeat (8) cyc(0, 16'h0001, 16'h1234, 1);
        // round-robin among three requesters
        cyc(1, 0, 0, 1);
        repeat (24) cyc(0, 16'h8101, 16'h8100, 1);
        // stall on ch3 then release
        cyc(1, 0, 0, 0);
        repeat (6) cyc(0, 16'h0008, 16'h0008, 0);
        repeat (6) cyc(0, 16'h0008, 16'h0000, 1);
        // early withdraw on ch5, next search from ch6
        cyc(1, 0, 0, 1);
        repeat (3) cyc(0, 16'h0020, 16'h00FF, 1);
        repeat (4) cyc(0, 16'hFFDF, 16'h00FF, 1);
        // out_bit follows data[sel] across every channel
        cyc(1, 0, 16'hA5C3, 1);
        for (int c = 0; c < 16; c++) begin
            rq = 16'h1 << c;
            repeat (3) cyc(0, rq, 16'hA5C3, c[0]);
        end
        // reset mid-transfer on ch9
        cyc(1, 0, 0, 1);
        repeat (3) cyc(0, 16'h0200, 16'h0200, 1);
        cyc(1, 16'h0200, 16'h0200, 1);
        repeat (4) cyc(0, 16'h0200, 16'h0000, 1);
        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
            cyc($urandom_range(0, 149) == 0, rq, 16'($urandom), $urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
